// File: rtl/pomo_timer_ctrl.sv
// pomo_timer_ctrl: work/rest countdown controller feeding a 4-digit seven-segment driver.
//
// Raw buttons are synchronized, debounced and turned into one-cycle press events.
// A small FSM then runs the work/rest countdown and the setpoint editor.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   btn_start   raw start/pause button (async, active-high)
//   btn_set     raw set/abort button (async, active-high)
//   btn_up      raw increment button (async, active-high)
//   xh          seconds remaining, BCD {tens, ones}
//   xq          {setpoint minutes of current phase, minutes remaining}
//   cstate_out  state code (WORK_INIT 000, REST_INIT 001, COUNT 011, PAUSE 010, SET_TIME 110)
//   phase_done  one-cycle pulse when a phase expires
module pomo_timer_ctrl #(
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned WORK_MIN   = 5,
  parameter int unsigned REST_MIN   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_set,
  input  logic       btn_up,
  output logic [7:0] xh,
  output logic [7:0] xq,
  output logic [2:0] cstate_out,
  output logic       phase_done
);

  localparam int unsigned DebW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned PreW = $clog2(TICK_DIV);
  localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);
  localparam logic [PreW-1:0] PreLast = PreW'(TICK_DIV - 1);
  localparam logic [3:0] WorkInit = 4'(WORK_MIN);
  localparam logic [3:0] RestInit = 4'(REST_MIN);

  typedef enum logic [2:0] {
    StWorkInit = 3'b000,
    StRestInit = 3'b001,
    StPause    = 3'b010,
    StCount    = 3'b011,
    StSetTime  = 3'b110
  } state_e;

  // ---------------------------------------------------------------------------
  // Button path: bit 0 start, bit 1 set, bit 2 up
  // ---------------------------------------------------------------------------
  logic [2:0]      btn_raw;
  logic [2:0]      sync1_q, sync2_q, acc_q, ev_q;
  logic [DebW-1:0] cnt_q [3];

  assign btn_raw = {btn_up, btn_set, btn_start};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      acc_q   <= '0;
      ev_q    <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      ev_q    <= '0;
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == acc_q[i]) begin
          // Level matches the accepted one: any pending change is abandoned.
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DebLast) begin
          acc_q[i] <= sync2_q[i];
          ev_q[i]  <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic ev_start, ev_set, ev_up;
  assign ev_start = ev_q[0];
  assign ev_set   = ev_q[1];
  assign ev_up    = ev_q[2];

  // ---------------------------------------------------------------------------
  // Timer FSM
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic            phase_q, phase_d;  // 0 work, 1 rest
  logic [3:0]      work_sp_q, work_sp_d, rest_sp_q, rest_sp_d;
  logic [3:0]      min_q, min_d, tens_q, tens_d, ones_q, ones_d;
  logic [3:0]      sp_disp_q, sp_disp_d;
  logic [PreW-1:0] presc_q, presc_d;
  logic            done_q, done_d;

  logic [3:0] sp_cur, sp_next;
  logic       tick, at_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StWorkInit;
      phase_q   <= 1'b0;
      work_sp_q <= WorkInit;
      rest_sp_q <= RestInit;
      min_q     <= WorkInit;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      sp_disp_q <= WorkInit;
      presc_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      work_sp_q <= work_sp_d;
      rest_sp_q <= rest_sp_d;
      min_q     <= min_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      sp_disp_q <= sp_disp_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    work_sp_d = work_sp_q;
    rest_sp_d = rest_sp_q;
    min_d     = min_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    sp_disp_d = sp_disp_q;
    done_d    = 1'b0;

    sp_cur  = phase_q ? rest_sp_q : work_sp_q;
    sp_next = (sp_cur >= 4'd9) ? 4'd1 : sp_cur + 4'd1;
    tick    = (state_q == StCount) && (presc_q == PreLast);
    at_zero = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);

    // Prescaler runs in COUNT, freezes in PAUSE so resume keeps the partial second.
    if (state_q == StCount) presc_d = tick ? '0 : presc_q + 1'b1;
    else if (state_q == StPause) presc_d = presc_q;
    else presc_d = '0;

    case (state_q)
      StWorkInit, StRestInit: begin
        if (ev_set) state_d = StSetTime;
        else if (ev_start) state_d = StCount;
      end
      StCount: begin
        if (tick && at_zero) begin
          done_d    = 1'b1;
          phase_d   = ~phase_q;
          state_d   = phase_q ? StWorkInit : StRestInit;
          min_d     = phase_q ? work_sp_q : rest_sp_q;
          sp_disp_d = phase_q ? work_sp_q : rest_sp_q;
          tens_d    = 4'd0;
          ones_d    = 4'd0;
        end else begin
          if (ev_set || ev_start) state_d = StPause;
          // A tick landing with a pause request still counts, so no second is lost.
          if (tick) begin
            if (ones_q != 4'd0) begin
              ones_d = ones_q - 4'd1;
            end else begin
              ones_d = 4'd9;
              if (tens_q != 4'd0) begin
                tens_d = tens_q - 4'd1;
              end else begin
                tens_d = 4'd5;
                min_d  = min_q - 4'd1;
              end
            end
          end
        end
      end
      StPause: begin
        if (ev_set) begin
          state_d   = phase_q ? StRestInit : StWorkInit;
          min_d     = sp_cur;
          sp_disp_d = sp_cur;
          tens_d    = 4'd0;
          ones_d    = 4'd0;
        end else if (ev_start) begin
          state_d = StCount;
        end
      end
      StSetTime: begin
        if (ev_set) begin
          state_d = phase_q ? StRestInit : StWorkInit;
        end else if (ev_up) begin
          if (phase_q) rest_sp_d = sp_next;
          else work_sp_d = sp_next;
          min_d     = sp_next;
          sp_disp_d = sp_next;
          tens_d    = 4'd0;
          ones_d    = 4'd0;
        end
      end
      default: state_d = StWorkInit;
    endcase
  end

  assign xh         = {tens_q, ones_q};
  assign xq         = {sp_disp_q, min_q};
  assign cstate_out = state_q;
  assign phase_done = done_q;

endmodule

// File: tb/tb_pomo_timer_ctrl.sv
module tb_pomo_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_set = 1'b0;
  logic       btn_up = 1'b0;
  logic [7:0] xh, xq;
  logic [2:0] cstate_out;
  logic       phase_done;

  int total = 0;
  int bad = 0;

  pomo_timer_ctrl #(
    .TICK_DIV  (4),
    .DEB_CYCLES(3),
    .WORK_MIN  (2),
    .REST_MIN  (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_set   (btn_set),
    .btn_up    (btn_up),
    .xh        (xh),
    .xq        (xq),
    .cstate_out(cstate_out),
    .phase_done(phase_done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    btn_start = 1'b0;
    btn_set   = 1'b0;
    btn_up    = 1'b0;
    rst       = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  // b: 0 start, 1 set, 2 up. 8 cycles high then 8 low so the debouncer settles.
  task automatic press(input int b);
    if (b == 0) btn_start = 1'b1;
    else if (b == 1) btn_set = 1'b1;
    else btn_up = 1'b1;
    step(8);
    btn_start = 1'b0;
    btn_set   = 1'b0;
    btn_up    = 1'b0;
    step(8);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (cstate_out !== 3'b000) begin bad++; $display("FAIL reset_cstate got=%b exp=000", cstate_out); end
    total++; if (xq !== 8'h22) begin bad++; $display("FAIL reset_xq got=%h exp=22", xq); end
    total++; if (xh !== 8'h00) begin bad++; $display("FAIL reset_xh got=%h exp=00", xh); end
    total++; if (phase_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", phase_done); end
  endtask

  task automatic test_start();
    btn_start = 1'b1;
    step(5);
    total++; if (cstate_out !== 3'b000) begin bad++; $display("FAIL start_early got=%b exp=000", cstate_out); end
    step(1);
    total++; if (cstate_out !== 3'b011) begin bad++; $display("FAIL start_count got=%b exp=011", cstate_out); end
    step(3);
    total++; if (xh !== 8'h00) begin bad++; $display("FAIL start_pretick got=%h exp=00", xh); end
    step(1);
    total++; if (xh !== 8'h59) begin bad++; $display("FAIL first_tick_xh got=%h exp=59", xh); end
    total++; if (xq !== 8'h21) begin bad++; $display("FAIL first_tick_xq got=%h exp=21", xq); end
    btn_start = 1'b0;
  endtask

  // Continues from 1:59 right after the first tick; ticks every 4 cycles.
  task automatic test_expiry();
    step(236);  // tick 60 -> 1:00
    total++; if (xq !== 8'h21 || xh !== 8'h00) begin bad++; $display("FAIL exp_1m00 got=%h:%h exp=21:00", xq, xh); end
    step(4);    // tick 61 -> 0:59
    total++; if (xq !== 8'h20 || xh !== 8'h59) begin bad++; $display("FAIL exp_0m59 got=%h:%h exp=20:59", xq, xh); end
    step(236);  // tick 120 -> 0:00
    total++; if (xq !== 8'h20 || xh !== 8'h00) begin bad++; $display("FAIL exp_zero got=%h:%h exp=20:00", xq, xh); end
    step(3);
    total++; if (cstate_out !== 3'b011 || phase_done !== 1'b0) begin
      bad++; $display("FAIL exp_hold got=%b/%b exp=011/0", cstate_out, phase_done);
    end
    step(1);
    total++; if (phase_done !== 1'b1) begin bad++; $display("FAIL exp_done got=%b exp=1", phase_done); end
    total++; if (cstate_out !== 3'b001) begin bad++; $display("FAIL exp_rest got=%b exp=001", cstate_out); end
    total++; if (xq !== 8'h11 || xh !== 8'h00) begin bad++; $display("FAIL exp_reload got=%h:%h exp=11:00", xq, xh); end
    step(1);
    total++; if (phase_done !== 1'b0) begin bad++; $display("FAIL exp_pulse got=%b exp=0", phase_done); end
  endtask

  task automatic test_glitch();
    do_reset();
    btn_start = 1'b1; step(2);
    btn_start = 1'b0; step(3);
    btn_start = 1'b1; step(2);
    btn_start = 1'b0; step(10);
    total++; if (cstate_out !== 3'b000 || xq !== 8'h22) begin
      bad++; $display("FAIL glitch got=%b/%h exp=000/22", cstate_out, xq);
    end
  endtask

  task automatic test_set_up();
    logic [3:0] seq [10];
    seq = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd1, 4'd2, 4'd3};
    press(1);
    total++; if (cstate_out !== 3'b110) begin bad++; $display("FAIL set_enter got=%b exp=110", cstate_out); end
    press(0);  // start is ignored while editing
    total++; if (cstate_out !== 3'b110) begin bad++; $display("FAIL set_ignore_start got=%b exp=110", cstate_out); end
    for (int i = 0; i < 10; i++) begin
      press(2);
      total++; if (xq !== {seq[i], seq[i]} || xh !== 8'h00) begin
        bad++; $display("FAIL up_%0d got=%h:%h exp=%h%h:00", i, xq, xh, seq[i], seq[i]);
      end
    end
    press(1);
    total++; if (cstate_out !== 3'b000) begin bad++; $display("FAIL set_exit got=%b exp=000", cstate_out); end
    total++; if (xq !== 8'h33 || xh !== 8'h00) begin bad++; $display("FAIL set_final got=%h:%h exp=33:00", xq, xh); end
  endtask

  // Work setpoint is 3 here. Cycle numbers in comments are relative to the first press.
  task automatic test_pause();
    press(0);  // COUNT from e6, ticks e10,e14 -> 2:58
    step(1);   // e17, prescaler at 3
    btn_start = 1'b1;
    step(6);   // tick e18,e22 -> 2:56; PAUSE at e23 holding prescaler 1
    total++; if (cstate_out !== 3'b010) begin bad++; $display("FAIL pause_enter got=%b exp=010", cstate_out); end
    total++; if (xq !== 8'h32 || xh !== 8'h56) begin bad++; $display("FAIL pause_time got=%h:%h exp=32:56", xq, xh); end
    step(2);
    btn_start = 1'b0;
    step(18);
    total++; if (xh !== 8'h56 || cstate_out !== 3'b010) begin
      bad++; $display("FAIL pause_frozen got=%h/%b exp=56/010", xh, cstate_out);
    end
    btn_start = 1'b1;
    step(6);   // resume, prescaler continues from 1
    total++; if (cstate_out !== 3'b011 || xh !== 8'h56) begin
      bad++; $display("FAIL resume got=%b/%h exp=011/56", cstate_out, xh);
    end
    step(2);
    total++; if (xh !== 8'h56) begin bad++; $display("FAIL resume_early got=%h exp=56", xh); end
    step(1);
    total++; if (xh !== 8'h55) begin bad++; $display("FAIL resume_tick got=%h exp=55", xh); end
    btn_start = 1'b0;
    step(8);
    press(1);  // set in COUNT only pauses
    total++; if (cstate_out !== 3'b010) begin bad++; $display("FAIL set_in_count got=%b exp=010", cstate_out); end
    press(1);
    total++; if (cstate_out !== 3'b000) begin bad++; $display("FAIL abort got=%b exp=000", cstate_out); end
    total++; if (xq !== 8'h33 || xh !== 8'h00) begin bad++; $display("FAIL abort_reload got=%h:%h exp=33:00", xq, xh); end
  endtask

  task automatic test_back_to_back();
    btn_set   = 1'b1;
    btn_start = 1'b1;
    step(6);
    total++; if (cstate_out !== 3'b110) begin bad++; $display("FAIL priority got=%b exp=110", cstate_out); end
    btn_set   = 1'b0;
    btn_start = 1'b0;
    step(8);
    press(1);
    press(0);
    total++; if (cstate_out !== 3'b011) begin bad++; $display("FAIL b2b_count got=%b exp=011", cstate_out); end
    step(3);
    rst = 1'b1;
    step(1);
    total++; if (cstate_out !== 3'b000) begin bad++; $display("FAIL midrst_cstate got=%b exp=000", cstate_out); end
    total++; if (xq !== 8'h22 || xh !== 8'h00) begin bad++; $display("FAIL midrst_time got=%h:%h exp=22:00", xq, xh); end
    rst = 1'b0;
    step(2);
  endtask

  initial begin
    test_reset();
    test_start();
    test_expiry();
    test_glitch();
    test_set_up();
    test_pause();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
